// File: rtl/watchdog_sec.sv
// watchdog_sec: seconds-granularity watchdog with warning interrupt and fixed-length bite pulse
module watchdog_sec #(
  parameter int TIMEOUT_S   = 8,
  parameter int WARN_S      = 2,
  parameter int CNT_WIDTH   = 8,
  parameter int BITE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_in,
  input  logic                 enable,
  input  logic                 kick,
  output logic                 warn_irq,
  output logic                 bite,
  output logic [CNT_WIDTH-1:0] secs_left,
  output logic [1:0]           state,
  output logic [3:0]           bite_count
);
  localparam int BW = $clog2(BITE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] TO = CNT_WIDTH'(TIMEOUT_S);
  localparam logic [CNT_WIDTH-1:0] WS = CNT_WIDTH'(WARN_S);
  localparam logic [BW-1:0] LAST = BW'(BITE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ARMED, WARN, BITE} st_t;
  st_t st, st_n;
  logic [CNT_WIDTH-1:0] secs_n, dec;
  logic [BW-1:0] bcnt, bcnt_n;
  assign dec = secs_left - 1'b1;
  assign state = st;
  assign warn_irq = st == WARN;
  always_comb begin
    st_n = st;
    secs_n = secs_left;
    bcnt_n = '0;
    case (st)
      IDLE: begin
        secs_n = TO;
        st_n = enable ? ARMED : IDLE;
      end
      ARMED: begin
        if (!enable) begin
          st_n = IDLE;
          secs_n = TO;
        end else if (kick) begin
          secs_n = TO;
        end else if (tick_in) begin
          secs_n = dec;
          st_n = dec == WS ? WARN : ARMED;
        end
      end
      WARN: begin
        if (!enable || kick) begin
          st_n = enable ? ARMED : IDLE;
          secs_n = TO;
        end else if (tick_in) begin
          st_n = secs_left == 1 ? BITE : WARN;
          secs_n = secs_left == 1 ? '0 : dec;
        end
      end
      BITE: begin
        // the pulse length is fixed; all inputs are ignored until it completes
        st_n = bcnt == LAST ? IDLE : BITE;
        secs_n = bcnt == LAST ? TO : secs_left;
        bcnt_n = bcnt == LAST ? '0 : bcnt + 1'b1;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      secs_left <= TO;
      bcnt <= '0;
      bite <= 1'b0;
      bite_count <= '0;
    end else begin
      st <= st_n;
      secs_left <= secs_n;
      bcnt <= bcnt_n;
      bite <= st_n == BITE;
      if (st != BITE && st_n == BITE && bite_count != 4'd15) bite_count <= bite_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_watchdog_sec.sv
// tb_watchdog_sec: directed and randomized checks of watchdog_sec against a behavioural model
module tb_watchdog_sec;
  localparam int TO = 8, WS = 2, BC = 16;
  logic clk = 0, rst = 1, tick_in = 0, enable = 0, kick = 0;
  logic warn_irq, bite;
  logic [7:0] secs_left;
  logic [1:0] state;
  logic [3:0] bite_count;
  int total = 0, bad = 0;
  int m_mode, m_secs, m_left, m_cnt;

  watchdog_sec #(.TIMEOUT_S(TO), .WARN_S(WS), .CNT_WIDTH(8), .BITE_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .enable(enable), .kick(kick),
    .warn_irq(warn_irq), .bite(bite), .secs_left(secs_left), .state(state), .bite_count(bite_count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 0; m_secs = TO; m_left = 0; m_cnt = 0;
  endfunction

  // mode: 0 idle, 1 armed, 2 warn, 3 bite; m_left counts bite cycles still to go
  function automatic void model(bit en, bit k, bit t);
    case (m_mode)
      0: begin m_secs = TO; if (en) m_mode = 1; end
      1: if (!en) begin m_mode = 0; m_secs = TO; end
         else if (k) m_secs = TO;
         else if (t) begin m_secs--; if (m_secs == WS) m_mode = 2; end
      2: if (!en) begin m_mode = 0; m_secs = TO; end
         else if (k) begin m_mode = 1; m_secs = TO; end
         else if (t) begin
           if (m_secs == 1) begin
             m_mode = 3; m_secs = 0; m_left = BC; m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
           end else m_secs--;
         end
      default: begin m_left--; if (m_left == 0) begin m_mode = 0; m_secs = TO; end end
    endcase
  endfunction

  task automatic step(input bit en, input bit k, input bit t);
    enable = en; kick = k; tick_in = t;
    @(posedge clk);
    model(en, k, t);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; enable = 0; kick = 0; tick_in = 0;
    @(posedge clk); #1;
    model_reset();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (secs_left !== 8'(TO)) begin bad++; $display("FAIL reset_secs got=%0d exp=%0d", secs_left, TO); end
    total++; if ({warn_irq, bite, bite_count} !== 6'd0) begin bad++; $display("FAIL reset_outs got=%b exp=0", {warn_irq, bite, bite_count}); end
  endtask

  task automatic test_expiry();
    int n;
    do_reset();
    step(1, 0, 0);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL arm_state got=%0d exp=1", state); end
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 1);
      if (i == 6) begin
        total++; if (state !== 2'd2 || secs_left !== 8'd2 || warn_irq !== 1'b1)
          begin bad++; $display("FAIL warn_at6 got st=%0d secs=%0d warn=%b exp st=2 secs=2 warn=1", state, secs_left, warn_irq); end
      end
      if (i < 8) step(1, 0, 0);
    end
    total++; if (state !== 2'd3 || secs_left !== 8'd0 || bite !== 1'b1 || warn_irq !== 1'b0)
      begin bad++; $display("FAIL bite_at8 got st=%0d secs=%0d bite=%b warn=%b exp 3/0/1/0", state, secs_left, bite, warn_irq); end
    n = 1;
    while (bite === 1'b1 && n < 100) begin step(1, 0, 0); if (bite === 1'b1) n++; end
    total++; if (n !== BC) begin bad++; $display("FAIL bite_len got=%0d exp=%0d", n, BC); end
    total++; if (state !== 2'd0 || bite_count !== 4'd1)
      begin bad++; $display("FAIL after_bite got st=%0d cnt=%0d exp st=0 cnt=1", state, bite_count); end
    step(1, 0, 0);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL rearm got=%0d exp=1", state); end
  endtask

  task automatic test_kick_periodic();
    int errs = 0;
    do_reset();
    step(1, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      step(1, 0, 1);
      if (warn_irq !== 1'b0 || bite !== 1'b0 || secs_left < 3 || secs_left !== 8'(m_secs)) errs++;
      if (i % 5 == 0) step(1, 1, 0);
      if (warn_irq !== 1'b0 || bite !== 1'b0 || secs_left < 3 || secs_left !== 8'(m_secs)) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL kick_periodic got=%0d bad cycles exp=0", errs); end
  endtask

  task automatic test_warn_kick();
    do_reset();
    step(1, 0, 0);
    repeat (6) step(1, 0, 1);
    total++; if (state !== 2'd2 || secs_left !== 8'd2) begin bad++; $display("FAIL warn_entry got st=%0d secs=%0d exp 2/2", state, secs_left); end
    step(1, 1, 0);
    total++; if (state !== 2'd1 || secs_left !== 8'(TO) || warn_irq !== 1'b0)
      begin bad++; $display("FAIL warn_kick got st=%0d secs=%0d warn=%b exp 1/8/0", state, secs_left, warn_irq); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1, 0, 0);
    repeat (3) step(1, 0, 1);
    total++; if (secs_left !== 8'd5) begin bad++; $display("FAIL pre_simul got=%0d exp=5", secs_left); end
    step(1, 1, 1);
    total++; if (secs_left !== 8'(TO) || state !== 2'd1) begin bad++; $display("FAIL kick_tick got secs=%0d st=%0d exp 8/1", secs_left, state); end
    step(1, 0, 1);
    step(0, 1, 1);
    total++; if (state !== 2'd0 || secs_left !== 8'(TO)) begin bad++; $display("FAIL en_drop got st=%0d secs=%0d exp 0/8", state, secs_left); end
  endtask

  task automatic test_bite_rst();
    int errs = 0;
    do_reset();
    step(1, 0, 0);
    repeat (8) step(1, 0, 1);
    for (int c = 1; c <= 7; c++) begin
      if (bite !== 1'b1 || state !== 2'd3) errs++;
      step(c % 2 == 0, c % 3 == 0, 1);
    end
    total++; if (errs !== 0 || bite !== 1'b1) begin bad++; $display("FAIL bite_ignore got=%0d bad cycles bite=%b exp 0/1", errs, bite); end
    #2 rst = 1;
    #1;
    total++; if (bite !== 1'b0 || state !== 2'd0 || secs_left !== 8'(TO) || bite_count !== 4'd0)
      begin bad++; $display("FAIL async_rst got bite=%b st=%0d secs=%0d cnt=%0d exp 0/0/8/0", bite, state, secs_left, bite_count); end
    model_reset();
    #2 rst = 0;
  endtask

  task automatic test_saturate();
    int n, errs = 0;
    do_reset();
    step(1, 0, 0);
    for (int b = 1; b <= 16; b++) begin
      repeat (8) step(1, 0, 1);
      n = 0;
      while (state !== 2'd0 && n < 100) begin step(1, 0, 0); n++; end
      if (n >= 100) errs++;
      if (bite_count !== 4'((b < 15) ? b : 15)) errs++;
      step(1, 0, 0);
      if (state !== 2'd1) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL saturate_seq got=%0d errors exp=0", errs); end
    total++; if (bite_count !== 4'd15) begin bad++; $display("FAIL saturate got=%0d exp=15", bite_count); end
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 31) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
      if (state !== 2'(m_mode) || secs_left !== 8'(m_secs) || bite !== (m_mode == 3) ||
          warn_irq !== (m_mode == 2) || bite_count !== 4'(m_cnt)) begin
        errs++;
        if (errs < 5) $display("FAIL random cyc=%0d got st=%0d secs=%0d bite=%b warn=%b cnt=%0d exp st=%0d secs=%0d cnt=%0d",
                               i, state, secs_left, bite, warn_irq, bite_count, m_mode, m_secs, m_cnt);
      end
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL random_total got=%0d exp=0", errs); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_expiry();
    test_kick_periodic();
    test_warn_kick();
    test_simultaneous();
    test_bite_rst();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/watchdog_sec.md
# watchdog_sec

Seconds-granularity watchdog that consumes the 1 Hz one-cycle tick from the design's pulse generator. Once enabled, firmware must kick it before a programmable number of seconds elapse. It raises a warning interrupt near expiry and, on expiry, drives a fixed-width bite pulse that the system-level reset logic uses. It sits directly downstream of the 1-second pulse generator, in the same clock domain.

## Interface
- TIMEOUT_S, 8: seconds from arm/kick to bite; must satisfy TIMEOUT_S > WARN_S and fit in CNT_WIDTH bits.
- WARN_S, 2: remaining-seconds value at which warning asserts; ≥ 1.
- CNT_WIDTH, 8: width of the seconds counter.
- BITE_CYCLES, 16: length of the bite pulse in clk cycles; ≥ 1.
- clk  input  1  system clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- tick_in  input  1  1-second tick; every cycle it is high counts as one second (upstream guarantees one-cycle pulses).
- enable  input  1  level; 1 = watchdog active.
- kick  input  1  one-cycle service strobe.
- warn_irq  output  1  high while state = WARN.
- bite  output  1  high for exactly BITE_CYCLES cycles on expiry.
- secs_left  output  CNT_WIDTH  seconds remaining, registered.
- state  output  2  IDLE=0, ARMED=1, WARN=2, BITE=3.
- bite_count  output  4  saturating count of bites since reset; cleared only by rst.

## Operation
- Reset values:
  - state = IDLE, secs_left = TIMEOUT_S.
  - warn_irq = 0, bite = 0, bite_count = 0.
  - Internal bite-length counter = 0.
- IDLE:
  - secs_left is held at TIMEOUT_S.
  - kick and tick_in are ignored.
  - enable = 1 → ARMED next cycle, secs_left = TIMEOUT_S.
- ARMED: priority order, highest first:
  1. enable = 0 → IDLE, secs_left = TIMEOUT_S.
  2. kick → secs_left = TIMEOUT_S, stay ARMED.
  3. tick_in → secs_left − 1. If the new value equals WARN_S, go to WARN.
- WARN: priority order, highest first:
  1. enable = 0 → IDLE, reload.
  2. kick → ARMED, reload TIMEOUT_S.
  3. tick_in with secs_left = 1 → BITE, secs_left = 0.
  4. Otherwise tick_in → secs_left − 1.
- BITE:
  - enable, kick and tick_in are all ignored.
  - Internal counter runs 0..BITE_CYCLES−1.
  - After the last cycle → IDLE, secs_left = TIMEOUT_S.
  - If enable is still 1, the normal IDLE → ARMED rule applies on the following cycle.
- bite_count increments by 1 on each IDLE-bound entry to BITE, saturating at 15.
- Simultaneous events:
  - kick together with tick_in: kick wins, counter reloads, no decrement.
  - enable drop together with kick or tick_in: enable drop wins.
- secs_left never underflows. The minimum reachable value is 0, and only in BITE.
- Widths:
  - secs_left arithmetic is unsigned CNT_WIDTH.
  - The bite-length counter is $clog2(BITE_CYCLES+1) bits.

## Timing
- All state, secs_left, bite_count and bite are registered.
- warn_irq is decoded from the registered state with no extra latency.
- Any input sampled at edge N takes effect in outputs after edge N.
- enable high at edge N → state = ARMED after edge N.
- Defaults, counting ticks from arming with no kick:
  - 6th tick → state = WARN, secs_left = 2, warn_irq = 1.
  - 8th tick → state = BITE, secs_left = 0, bite = 1, warn_irq = 0.
- bite rises the cycle state becomes BITE.
- bite stays high for exactly BITE_CYCLES cycles.
- state reads IDLE in the cycle bite falls.
- Asynchronous reset mid-BITE: bite drops immediately and all outputs return to their reset values; bite_count also clears.

## Test plan
- Reset, then enable = 1, no kicks, 8 ticks → warn_irq rises after the 6th tick with secs_left = 2. After the 8th tick: bite high for 16 cycles, then state = IDLE, bite_count = 1.
- Armed, kick every 5 ticks for 40 ticks → warn_irq never asserts, bite never asserts, secs_left ≥ 3 throughout.
- In WARN (secs_left = 2), kick → state = ARMED, secs_left = 8, warn_irq = 0 the next cycle.
- kick and tick_in in the same cycle with secs_left = 5 → secs_left = 8 and no decrement. enable = 0 together with kick → state = IDLE.
- During BITE, toggle enable and kick, and assert rst at bite cycle 7:
  - Before rst, enable and kick have no effect on bite.
  - After rst: bite = 0 immediately, state = IDLE, secs_left = 8, bite_count = 0.
- Force 16 consecutive bites with enable held high → bite_count saturates at 15; the watchdog re-arms one cycle after each return to IDLE.
